// File: rtl/apb_pkg.sv
// Shared APB arbiter types and UART register addresses.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam logic [31:0] UART_THR = 32'h1000_0000;
  localparam logic [31:0] UART_LSR = 32'h1000_0005;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered last-grant bit.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = last_grant_q ? 2'b01 : 2'b10;
    end
    last_grant_d = last_grant_q;
    if (en && (|req)) begin
      last_grant_d = gnt[1];
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS
// sequencing, per-port response registers and access timeout.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  ready,
  input  logic                  perr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [3:0] pstb_q, pstb_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic pwrite_q, pwrite_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic [1:0] req_m;
  logic [1:0] gnt;
  logic       grant_en;
  logic       cur;
  logic       done;
  logic       wr;
  logic       rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // A requester is masked during its own ack cycle.
  assign req_m = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

  rr_arb2 u_arb (
    .clk        (pclk),
    .rst        (rst),
    .req        (req_m),
    .en         (grant_en),
    .gnt        (gnt),
    .last_grant (cur)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pdata_d   = pdata_q;
    pstb_d    = pstb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    ack_d     = 2'b00;
    err_d     = err_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    grant_en  = 1'b0;
    done      = 1'b0;
    wr        = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_m) begin
          grant_en = 1'b1;
          wr       = gnt[1] ? m1_write : m0_write;
          paddr_d  = gnt[1] ? m1_addr : m0_addr;
          pwrite_d = wr;
          pdata_d  = '0;
          pstb_d   = 4'b0000;
          if (wr) begin
            pdata_d = gnt[1] ? m1_wdata : m0_wdata;
            pstb_d  = gnt[1] ? m1_stb : m0_stb;
          end
          psel_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (ready) begin
          done     = 1'b1;
          rsp_data = prdata;
          rsp_err  = perr;
        end else if (TIMEOUT != 0 && cnt_q == TMAX) begin
          done    = 1'b1;
          rsp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
          ack_d[cur] = 1'b1;
          err_d[cur] = rsp_err;
          if (cur) begin
            rdata1_d = rsp_data;
          end else begin
            rdata0_d = rsp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pdata_q   <= '0;
      pstb_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      pstb_q    <= pstb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign paddr    = paddr_q;
  assign pdata    = pdata_q;
  assign pstb     = pstb_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule
